counter_sched: RTL and testbench
================================

# counter_sched

Synchronous controller that shares one up-counter resource between two requesters. It grants the counter round-robin and runs a prescaled count from 0 to the winner's terminal value. It then pulses that requester's `done` and releases the counter. It replaces the free-running ripple chain in designs that need a clean, single-clock, arbitrated count session instead of a 555-clocked ripple counter.

## Interface
- `WIDTH`, 2, counter width in bits
- `PRESC_W`, 8, prescaler width in bits

- `clk`  in  1  single system clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high reset
- `req`  in  2  request per requester; level, held until `done` or withdrawn
- `tc_a`  in  WIDTH  terminal count for requester 0
- `tc_b`  in  WIDTH  terminal count for requester 1
- `presc`  in  PRESC_W  tick period minus one, in `clk` cycles
- `grant`  out  2  one-hot owner of the counter; 0 when free
- `busy`  out  1  high in RUN
- `count`  out  WIDTH  current count value
- `tick`  out  1  one-cycle pulse on each count step
- `done`  out  2  one-cycle pulse to the owner at session end

## Operation
- States are IDLE, RUN and DONE.
- Reset (synchronous, active-high) produces: IDLE, `grant`=0, `busy`=0, `count`=0, `tick`=0, `done`=0, prescaler=0, and the round-robin pointer favouring requester 0.
- IDLE:
  - If any `req` bit is high, select the owner.
  - On a single request, grant that requester.
  - On both requests, grant the requester not served last; after reset, grant requester 0.
  - Latch the owner's `tc_*` and `presc`, clear `count` and the prescaler, and go to RUN.
- RUN:
  - The prescaler `pcnt` increments each cycle.
  - When `pcnt`==latched presc, `tick`=1 and `pcnt` returns to 0.
  - On a tick with `count`!=latched tc, `count` increments.
  - On a tick with `count`==latched tc, go to DONE and clear `count`.
- Abort: if the owner's `req` drops in RUN, go to IDLE next edge with `count`=0 and no `done` pulse. The pointer still records that owner as served.
- DONE (one cycle):
  - `done[owner]`=1 and `grant`=0.
  - Update the pointer to the other requester.
  - Go to IDLE.
- `tc`=0: the session ends on the first tick.
- `count` never wraps inside a session. Terminal value 2^WIDTH−1 is legal and ends without overflow.
- The latched tc and presc are immune to input changes during RUN.
- A non-owner `req` during RUN is ignored until IDLE; there is no preemption.

## Timing
- `grant` rises one edge after `req` is seen high in IDLE, and stays high for all of RUN.
- First `tick` occurs presc+1 cycles after RUN entry. Subsequent ticks occur every presc+1 cycles.
- `count` changes on the edge that ends a tick cycle, so `tick` and the old `count` are visible together.
- Session length from `grant` rise to the `done` cycle is (tc+1)·(presc+1) cycles.
- `done` is high exactly one cycle, in the cycle after the final tick, with `grant`=0 in that cycle.
- Re-grant happens no earlier than one cycle after `done` (the IDLE cycle); minimum gap between sessions is 2 cycles.
- `reset` asserted in any state returns all outputs to reset values on the next edge. No `done` is produced by reset.

## Configuration
- `COUNTER_SCHED_HOLD_EN` defined:
  - Adds input port `hold` (1 bit).
  - While `hold`=1 in RUN, the prescaler and `count` freeze and `tick`=0.
  - `grant` and `busy` stay high, and abort on `req` drop still applies.
- `COUNTER_SCHED_HOLD_EN` undefined: there is no `hold` port and the prescaler runs unconditionally in RUN.

## Test plan
1. Reset, then `req`=01, tc_a=3, presc=0:
   - `grant`=01 after 1 cycle.
   - `count` goes 0,1,2,3 on consecutive cycles.
   - `done`=01 for 1 cycle, then `grant`=00.
2. `req`=01, tc_a=1, presc=2: ticks occur at RUN cycles 3 and 6, and `done` follows in cycle 7.
3. `req`=11 held continuously, tc_a=tc_b=0, presc=0:
   - Grants alternate 01, 10, 01, …
   - Each grant is followed by the matching `done` pulse.
4. `req`=01, tc_a=3, presc=3, then drop `req[0]` after the first tick: next edge gives IDLE, `count`=0, and no `done`.
5. Assert `reset` mid-RUN with `count`=2: the next edge gives all outputs 0, and a later `req`=11 grants requester 0.
6. (`COUNTER_SCHED_HOLD_EN`) presc=0, tc_a=3, `hold`=1 for 4 cycles at `count`=1:
   - `count` stays 1 and `tick`=0 during hold.
   - Session length grows by exactly 4 cycles.

Source files
------------

// File: rtl/counter_sched_if.sv
// rtl/counter_sched_if.sv - request/grant and count bus for counter_sched
// Optional hold signal present when COUNTER_SCHED_HOLD_EN is defined.
interface counter_sched_if #(
  parameter int WIDTH   = 2,
  parameter int PRESC_W = 8
);
  logic [1:0]         req;
  logic [WIDTH-1:0]   tc_a;
  logic [WIDTH-1:0]   tc_b;
  logic [PRESC_W-1:0] presc;
  logic [1:0]         grant;
  logic               busy;
  logic [WIDTH-1:0]   count;
  logic               tick;
  logic [1:0]         done;
`ifdef COUNTER_SCHED_HOLD_EN
  logic               hold;

  modport master (output req, tc_a, tc_b, presc, hold,
                  input  grant, busy, count, tick, done);
  modport slave  (input  req, tc_a, tc_b, presc, hold,
                  output grant, busy, count, tick, done);
`else
  modport master (output req, tc_a, tc_b, presc,
                  input  grant, busy, count, tick, done);
  modport slave  (input  req, tc_a, tc_b, presc,
                  output grant, busy, count, tick, done);
`endif
endinterface

// File: rtl/counter_sched.sv
// rtl/counter_sched.sv - round-robin arbitrated prescaled up-counter for two requesters
// Define COUNTER_SCHED_HOLD_EN to add the hold input that freezes a running session.
module counter_sched #(
  parameter int WIDTH   = 2,
  parameter int PRESC_W = 8
) (
  input  logic            clk,
  input  logic            reset,
  counter_sched_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t             state;
  logic               owner;
  logic               rr_ptr;
  logic [WIDTH-1:0]   tc_l;
  logic [PRESC_W-1:0] presc_l;
  logic [PRESC_W-1:0] pcnt;
  logic [WIDTH-1:0]   count_r;
  logic [1:0]         grant_r;
  logic [1:0]         done_r;
  logic               hold_w;
  logic               tick_w;
  logic               owner_req;
  logic               pick;

`ifdef COUNTER_SCHED_HOLD_EN
  assign hold_w = bus.hold;
`else
  assign hold_w = 1'b0;
`endif

  assign tick_w    = (state == S_RUN) && !hold_w && (pcnt == presc_l);
  assign owner_req = bus.req[owner];

  // rr_ptr names the requester preferred on contention (0 after reset)
  always_comb begin
    pick = 1'b0;
    if (bus.req == 2'b11) begin
      pick = rr_ptr;
    end else begin
      pick = bus.req[1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      owner   <= 1'b0;
      rr_ptr  <= 1'b0;
      tc_l    <= '0;
      presc_l <= '0;
      pcnt    <= '0;
      count_r <= '0;
      grant_r <= 2'b00;
      done_r  <= 2'b00;
    end else begin
      done_r <= 2'b00;
      case (state)
        S_IDLE: begin
          if (|bus.req) begin
            owner   <= pick;
            grant_r <= pick ? 2'b10 : 2'b01;
            tc_l    <= pick ? bus.tc_b : bus.tc_a;
            presc_l <= bus.presc;
            pcnt    <= '0;
            count_r <= '0;
            state   <= S_RUN;
          end
        end
        S_RUN: begin
          // Abort wins over a coincident final tick: no done is issued
          if (!owner_req) begin
            state   <= S_IDLE;
            grant_r <= 2'b00;
            count_r <= '0;
            pcnt    <= '0;
            rr_ptr  <= ~owner;
          end else if (tick_w) begin
            pcnt <= '0;
            if (count_r == tc_l) begin
              count_r <= '0;
              grant_r <= 2'b00;
              done_r  <= owner ? 2'b10 : 2'b01;
              state   <= S_DONE;
            end else begin
              count_r <= count_r + 1'b1;
            end
          end else if (!hold_w) begin
            pcnt <= pcnt + 1'b1;
          end
        end
        S_DONE: begin
          rr_ptr <= ~owner;
          state  <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.grant = grant_r;
  assign bus.busy  = (state == S_RUN);
  assign bus.count = count_r;
  assign bus.tick  = tick_w;
  assign bus.done  = done_r;

endmodule

// File: tb/tb_counter_sched.sv
// tb/tb_counter_sched.sv - scoreboard bench for counter_sched with a session-level reference model
// Exercises hold sessions as well when COUNTER_SCHED_HOLD_EN is defined.
module tb_counter_sched;

  localparam int W  = 2;
  localparam int PW = 8;
  localparam int K_GRANT = 0;
  localparam int K_DONE  = 1;
  localparam int K_ABORT = 2;

  typedef struct {
    int kind;
    int owner;
    int cyc;
    int presc;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  exp_t sb[$];

  int m_ptr;
  int idle_at;

  counter_sched_if #(.WIDTH(W), .PRESC_W(PW)) bus ();

  counter_sched #(.WIDTH(W), .PRESC_W(PW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int expv);
    tests++;
    if (act != expv) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  // mode: 0 complete, 1 abort by req drop, 2 reset; at: RUN cycle of the event (0 = random)
  task automatic session(input logic [1:0] r, input int ta, input int tb, input int pr,
                         input int mode, input int at, input int hold_n, input bit poke);
    int own, tc, m, len, a, d;
    exp_t e;
    wait_cyc(idle_at);
    m = cyc;
    bus.req   = r;
    bus.tc_a  = W'(ta);
    bus.tc_b  = W'(tb);
    bus.presc = PW'(pr);
    own = (r == 2'b11) ? m_ptr : int'(r[1]);
    tc  = own ? tb : ta;
    len = (tc + 1) * (pr + 1);
    e.kind = K_GRANT; e.owner = own; e.cyc = m + 1; e.presc = pr;
    sb.push_back(e);
    wait_cyc(m + 1);
    bus.tc_a  = W'($urandom);
    bus.tc_b  = W'($urandom);
    bus.presc = PW'($urandom_range(0, 7));
    if (poke) bus.req = 2'b11;
    a = (at > 0) ? at : 1 + int'($urandom % len);
    if (mode == 1) begin
      wait_cyc(m + a);
      bus.req = 2'b00;
      e.kind = K_ABORT; e.cyc = m + a + 1;
      sb.push_back(e);
      m_ptr   = 1 - own;
      idle_at = m + a + 1;
    end else if (mode == 2) begin
      wait_cyc(m + a);
      reset = 1'b1;
      e.kind = K_ABORT; e.cyc = m + a + 1;
      sb.push_back(e);
      m_ptr = 0;
      wait_cyc(m + a + 1);
      reset   = 1'b0;
      bus.req = 2'b00;
      idle_at = m + a + 1;
    end else begin
`ifdef COUNTER_SCHED_HOLD_EN
      if (hold_n > 0) begin
        wait_cyc(m + 2);
        bus.hold = 1'b1;
        wait_cyc(m + 2 + hold_n);
        bus.hold = 1'b0;
      end
`endif
      d = m + 1 + len + hold_n;
      e.kind = K_DONE; e.cyc = d;
      sb.push_back(e);
      wait_cyc(d);
      bus.req = 2'b00;
      m_ptr   = 1 - own;
      idle_at = d + 1;
    end
  endtask

  // Monitor: pops scoreboard events on grant edges, checks count/tick against session position
  logic [1:0] prev_grant = 2'b00;
  int   mk, mp, mown, hold_v;
  exp_t got;

  always @(negedge clk) begin
    if (cyc >= 1) begin
`ifdef COUNTER_SCHED_HOLD_EN
      hold_v = int'(bus.hold);
`else
      hold_v = 0;
`endif
      if (bus.grant != 2'b00 && prev_grant == 2'b00) begin
        if (sb.size() == 0) begin
          chk("unexpected_grant", int'(bus.grant), 0);
        end else begin
          got = sb.pop_front();
          chk("grant_kind", K_GRANT, got.kind);
          chk("grant_cycle", cyc, got.cyc);
          mown = got.owner;
          mp   = got.presc + 1;
          mk   = 1;
        end
      end
      if (bus.grant != 2'b00) begin
        chk("grant_onehot", int'(bus.grant), mown ? 2 : 1);
        chk("busy_run", int'(bus.busy), 1);
        chk("count_run", int'(bus.count), (mk - 1) / mp);
        chk("tick_run", int'(bus.tick), (hold_v == 0 && (mk % mp) == 0) ? 1 : 0);
        chk("done_run", int'(bus.done), 0);
        if (hold_v == 0) mk++;
      end else begin
        if (prev_grant != 2'b00) begin
          if (sb.size() == 0) begin
            chk("unexpected_end", int'(bus.done), 0);
          end else begin
            got = sb.pop_front();
            chk("end_kind", (bus.done != 2'b00) ? K_DONE : K_ABORT, got.kind);
            chk("end_cycle", cyc, got.cyc);
            chk("done_value", int'(bus.done), (got.kind == K_DONE) ? (got.owner ? 2 : 1) : 0);
          end
        end else begin
          chk("done_idle", int'(bus.done), 0);
        end
        chk("busy_idle", int'(bus.busy), 0);
        chk("count_idle", int'(bus.count), 0);
        chk("tick_idle", int'(bus.tick), 0);
      end
      prev_grant = bus.grant;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int r, md, pk;
    reset     = 1'b1;
    bus.req   = 2'b00;
    bus.tc_a  = '0;
    bus.tc_b  = '0;
    bus.presc = '0;
`ifdef COUNTER_SCHED_HOLD_EN
    bus.hold  = 1'b0;
`endif
    m_ptr = 0;
    wait_cyc(3);
    reset   = 1'b0;
    idle_at = cyc;

    session(2'b01, 3, 0, 0, 0, 0, 0, 1'b0);
    session(2'b01, 1, 0, 2, 0, 0, 0, 1'b0);
    for (int i = 0; i < 4; i++) session(2'b11, 0, 0, 0, 0, 0, 0, 1'b0);
    session(2'b01, 3, 0, 3, 1, 5, 0, 1'b0);
    session(2'b01, 3, 0, 0, 0, 0, 0, 1'b0);
    session(2'b10, 0, 3, 0, 2, 3, 0, 1'b0);
    session(2'b11, 1, 2, 1, 0, 0, 0, 1'b0);
    session(2'b01, 3, 0, 0, 0, 0, 0, 1'b1);
`ifdef COUNTER_SCHED_HOLD_EN
    session(2'b01, 3, 0, 0, 0, 0, 4, 1'b0);
`endif

    for (int i = 0; i < 40; i++) begin
      r  = $urandom_range(1, 3);
      md = $urandom_range(0, 9);
      pk = $urandom_range(0, 3);
      session(2'(r), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 4),
              (md < 2) ? 1 : ((md == 2) ? 2 : 0), 0, 0, (pk == 0 && r != 3));
    end

    wait_cyc(idle_at + 5);
    chk("queue_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
